// File: rtl/carry_skip_adder.sv
// Carry-skip adder: BLOCK-bit ripple groups with a per-group bypass mux
// on the inter-group carry, followed by registered sum and carry-out.
module carry_skip_adder #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NG = WIDTH / BLOCK;

  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] sum_q;
  logic [NG:0]      gc;
  logic             rc;
  logic             cout_d;
  logic             cout_q;

  assign p = a ^ b;
  assign g = a & b;

  // Sum bits always use the ripple chain; only gc[k+1] takes the bypass.
  always_comb begin
    gc    = '0;
    sum_d = '0;
    rc    = 1'b0;
    for (int k = 0; k < NG; k++) begin
      rc = gc[k];
      for (int j = 0; j < BLOCK; j++) begin
        sum_d[k*BLOCK+j] = p[k*BLOCK+j] ^ rc;
        rc = g[k*BLOCK+j] | (p[k*BLOCK+j] & rc);
      end
      gc[k+1] = (&p[k*BLOCK +: BLOCK]) ? gc[k] : rc;
    end
  end

  assign cout_d = gc[NG];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_carry_skip_adder.sv
// Bench for carry_skip_adder: 16/4 and 32/8 instances driven in lockstep,
// expected {cout,sum} queued at drive time and checked after the edge.
module tb_carry_skip_adder;

  logic        clk;
  logic        rst_n;
  logic [15:0] a16, b16, s16;
  logic        c16;
  logic [31:0] a32, b32, s32;
  logic        c32;

  int errors = 0;
  int checks = 0;

  carry_skip_adder u16 (
    .clk(clk), .rst_n(rst_n),
    .a(a16), .b(b16), .sum(s16), .cout(c16)
  );

  carry_skip_adder #(.WIDTH(32), .BLOCK(8)) u32 (
    .clk(clk), .rst_n(rst_n),
    .a(a32), .b(b32), .sum(s32), .cout(c32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [16:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [16:0] e16;
    logic [32:0] e32;
  } exp_t;

  exp_t sbq[$];
  vec_t tbl[7];

  task automatic check_out();
    exp_t q;
    if (sbq.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard-empty");
      return;
    end
    q = sbq.pop_front();
    checks++;
    if ({c16, s16} !== q.e16) begin
      errors++;
      $display("FAIL %s w16 got=%h exp=%h", q.name, {c16, s16}, q.e16);
    end
    checks++;
    if ({c32, s32} !== q.e32) begin
      errors++;
      $display("FAIL %s w32 got=%h exp=%h", q.name, {c32, s32}, q.e32);
    end
  endtask

  task automatic drive(input string nm, input logic r,
                       input logic [15:0] av, input logic [15:0] bv,
                       input logic [31:0] av32, input logic [31:0] bv32,
                       input logic [16:0] e16);
    exp_t q;
    @(negedge clk);
    rst_n = r;
    a16 = av;
    b16 = bv;
    a32 = av32;
    b32 = bv32;
    q.name = nm;
    q.e16 = r ? e16 : 17'h0;
    q.e32 = r ? ({1'b0, av32} + {1'b0, bv32}) : 33'h0;
    sbq.push_back(q);
    @(posedge clk);
    #1 check_out();
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic [31:0] ra32, rb32;

    tbl[0] = '{16'hFFEE, 16'hFFEE, 17'h1FFDC};
    tbl[1] = '{16'hFEEF, 16'hFEEF, 17'h1FDDE};
    tbl[2] = '{16'hF1EF, 16'hF1EF, 17'h1E3DE};
    tbl[3] = '{16'h0110, 16'h0110, 17'h00220};
    tbl[4] = '{16'hFFFF, 16'h0001, 17'h10000};
    tbl[5] = '{16'hF0F0, 16'h0F0F, 17'h0FFFF};
    tbl[6] = '{16'h000F, 16'h0001, 17'h00010};

    rst_n = 1'b0;
    a16 = '0; b16 = '0; a32 = '0; b32 = '0;

    drive("reset0", 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 17'h0);
    drive("reset1", 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 17'h0);
    drive("release", 1'b1, 16'hFFFF, 16'hFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 17'h1FFFE);

    for (int i = 1; i <= 16'h1E; i++)
      drive("dbl_lo", 1'b1, 16'(i), 16'(i), 32'(i), 32'(i), 17'(2 * i));
    for (int i = 16'h10; i <= 16'hF0; i += 16'h10)
      drive("dbl_hi", 1'b1, 16'(i), 16'(i), 32'(i), 32'(i), 17'(2 * i));

    for (int i = 0; i < 7; i++)
      drive($sformatf("vec%0d", i), 1'b1, tbl[i].a, tbl[i].b,
            {tbl[i].a, tbl[i].a}, {tbl[i].b, tbl[i].b}, tbl[i].exp);

    drive("w32_carry", 1'b1, 16'hFFFF, 16'h0001, 32'hFFFFFFFF, 32'h00000001, 17'h10000);
    drive("w32_prop", 1'b1, 16'hF0F0, 16'h0F0F, 32'hF0F0F0F0, 32'h0F0F0F0F, 17'h0FFFF);

    for (int i = 0; i < 10000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      ra32 = $urandom;
      rb32 = $urandom;
      drive("rand", (i != 5000), ra, rb, ra32, rb32, {1'b0, ra} + {1'b0, rb});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
